// File: rtl/nes_dual_poll_scheduler.sv
// Purpose : polls two NES pads through one shared nes_controller reader, once every FRAME_DIV vblank edges.
// Latency : request 1 cycle after the start edge; results published 1 cycle after pad 1 answers or times out.
// Backpress: none; vblank edges arriving while a poll is in flight are dropped and i_valid outside WAIT is ignored.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_vblank, i_enable              frame timing level and polling enable (enable sampled in IDLE)
//   o_read_buttons                  one-cycle read request to nes_controller
//   i_valid, i_buttons              nes_controller result strobe and byte
//   o_data_sel                      pad data-line mux select (0 = pad 0, 1 = pad 1)
//   o_p0_buttons, o_p1_buttons      held button state per pad
//   o_p0_pressed, o_p1_pressed      newly pressed buttons, valid only with o_update
//   o_update                        one-cycle publish strobe
//   o_timeout                       per-pad timeout status of the last poll
//   o_busy                          a poll is in progress
module nes_dual_poll_scheduler #(
    parameter int FRAME_DIV      = 1,
    parameter int SEL_SETTLE     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vblank,
    input  logic       i_enable,
    output logic       o_read_buttons,
    input  logic       i_valid,
    input  logic [7:0] i_buttons,
    output logic       o_data_sel,
    output logic [7:0] o_p0_buttons,
    output logic [7:0] o_p1_buttons,
    output logic [7:0] o_p0_pressed,
    output logic [7:0] o_p1_pressed,
    output logic       o_update,
    output logic [1:0] o_timeout,
    output logic       o_busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(SEL_SETTLE - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_SETTLE, S_REQ1, S_WAIT1, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          vblank_q;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    smp0, smp1;
    logic [1:0]    tmo;

    logic vblank_rise, qual_edge, start, timer_last, publish;

    assign vblank_rise = i_vblank & ~vblank_q;
    assign qual_edge   = (state == S_IDLE) && i_enable && vblank_rise;
    assign start       = qual_edge && (div_cnt == DIV_LAST);
    assign timer_last  = (timer == TMO_LAST);
    // Results are registered on the WAIT1 exit edge so they are already visible in the DONE cycle.
    assign publish     = (state == S_WAIT1) && (i_valid || timer_last);

    always_comb begin
        state_nxt      = state;
        o_read_buttons = 1'b0;
        o_data_sel     = 1'b0;
        o_update       = 1'b0;
        o_busy         = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) state_nxt = S_REQ0;
            S_REQ0: begin
                o_read_buttons = 1'b1;
                state_nxt      = S_WAIT0;
            end
            S_WAIT0:  if (i_valid || timer_last) state_nxt = S_SETTLE;
            S_SETTLE: begin
                o_data_sel = 1'b1;
                if (timer == SET_LAST) state_nxt = S_REQ1;
            end
            S_REQ1: begin
                o_data_sel     = 1'b1;
                o_read_buttons = 1'b1;
                state_nxt      = S_WAIT1;
            end
            S_WAIT1: begin
                o_data_sel = 1'b1;
                if (i_valid || timer_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_data_sel = 1'b1;
                o_update   = 1'b1;
                state_nxt  = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            vblank_q <= 1'b1;   // a vblank already high out of reset must not count as an edge
            div_cnt  <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            vblank_q <= i_vblank;
            if (qual_edge)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            // One timer serves both the WAIT timeout and the SETTLE count; it restarts on every state change.
            if (state_nxt != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            smp0         <= '0;
            smp1         <= '0;
            tmo          <= '0;
            o_p0_buttons <= '0;
            o_p1_buttons <= '0;
            o_p0_pressed <= '0;
            o_p1_pressed <= '0;
            o_timeout    <= '0;
        end else begin
            o_p0_pressed <= '0;
            o_p1_pressed <= '0;
            if (state == S_WAIT0) begin
                if (i_valid) begin
                    smp0   <= i_buttons;
                    tmo[0] <= 1'b0;
                end else if (timer_last) begin
                    tmo[0] <= 1'b1;
                end
            end
            if (state == S_WAIT1) begin
                if (i_valid) begin
                    smp1   <= i_buttons;
                    tmo[1] <= 1'b0;
                end else if (timer_last) begin
                    tmo[1] <= 1'b1;
                end
            end
            if (publish) begin
                o_p0_buttons <= smp0;
                o_p1_buttons <= i_valid ? i_buttons : smp1;
                o_p0_pressed <= tmo[0] ? 8'h00 : (smp0 & ~o_p0_buttons);
                o_p1_pressed <= i_valid ? (i_buttons & ~o_p1_buttons) : 8'h00;
                o_timeout    <= {~i_valid, tmo[0]};
            end
        end
    end

endmodule

// File: tb/tb_nes_dual_poll_scheduler.sv
// Purpose : directed checks of nes_dual_poll_scheduler using two instances (FRAME_DIV=1/long timeout, FRAME_DIV=3/short timeout).
// Latency : pad models answer a fixed number of cycles after each request.
// Backpress: none; each instance has its own vblank, valid and button inputs.
module tb_nes_dual_poll_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n, en;
    logic       vb_a, vld_a, vb_b, vld_b;
    logic [7:0] btn_a, btn_b;
    logic       a_req, a_sel, a_upd, a_busy, b_req, b_sel, b_upd, b_busy;
    logic [7:0] a_b0, a_b1, a_p0, a_p1, b_b0, b_b1, b_p0, b_p1;
    logic [1:0] a_to, b_to;

    nes_dual_poll_scheduler #(.FRAME_DIV(1), .SEL_SETTLE(4), .TIMEOUT_CYCLES(4096)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_vblank(vb_a), .i_enable(en),
        .o_read_buttons(a_req), .i_valid(vld_a), .i_buttons(btn_a), .o_data_sel(a_sel),
        .o_p0_buttons(a_b0), .o_p1_buttons(a_b1), .o_p0_pressed(a_p0), .o_p1_pressed(a_p1),
        .o_update(a_upd), .o_timeout(a_to), .o_busy(a_busy));

    nes_dual_poll_scheduler #(.FRAME_DIV(3), .SEL_SETTLE(4), .TIMEOUT_CYCLES(64)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_vblank(vb_b), .i_enable(en),
        .o_read_buttons(b_req), .i_valid(vld_b), .i_buttons(btn_b), .o_data_sel(b_sel),
        .o_p0_buttons(b_b0), .o_p1_buttons(b_b1), .o_p0_pressed(b_p0), .o_p1_pressed(b_p1),
        .o_update(b_upd), .o_timeout(b_to), .o_busy(b_busy));

    // pad model configuration (written by the main sequence only)
    logic [7:0] val_a[2], val_b[2];
    bit         rsp_a[2], rsp_b[2];
    int         lat_a, lat_b;
    int         stray_at_b = -1;

    // observations (written by the pad models only)
    int         nreq_a = 0, nupd_a = 0, upd_cyc_a = 0, nreq_b = 0, nupd_b = 0, upd_cyc_b = 0;
    int         req_cyc_a[2], req_cyc_b[2];
    logic [7:0] ua[4], ub[4];
    logic [1:0] ua_to, ub_to;
    logic       ua_sel, pa_busy, pa_sel;
    int         bad_pr = 0;

    // pad model for dut_a: answers lat_a cycles after each request from the pad selected at request time
    initial begin
        int cnt, pad;
        bit post;
        cnt = 0; pad = 0; post = 0;
        vld_a = 1'b0; btn_a = 8'h00;
        forever begin
            @(posedge clk); #1;
            vld_a = 1'b0;
            if (post) begin pa_busy = a_busy; pa_sel = a_sel; post = 0; end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin vld_a = 1'b1; btn_a = val_a[pad]; end
            end
            if (a_req) begin
                pad = int'(a_sel); req_cyc_a[pad] = cyc; nreq_a++;
                if (rsp_a[pad]) cnt = lat_a;
            end
            if (a_upd) begin
                nupd_a++; upd_cyc_a = cyc; ua_sel = a_sel; post = 1;
                ua[0] = a_b0; ua[1] = a_b1; ua[2] = a_p0; ua[3] = a_p1; ua_to = a_to;
            end
            if (!a_upd && (a_p0 | a_p1) != 8'h00) bad_pr++;
        end
    end

    // pad model for dut_b, plus an optional stray strobe at a chosen cycle
    initial begin
        int cnt, pad;
        cnt = 0; pad = 0;
        vld_b = 1'b0; btn_b = 8'h00;
        forever begin
            @(posedge clk); #1;
            vld_b = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin vld_b = 1'b1; btn_b = val_b[pad]; end
            end
            if (cyc == stray_at_b) begin vld_b = 1'b1; btn_b = 8'hFF; end
            if (b_req) begin
                pad = int'(b_sel); req_cyc_b[pad] = cyc; nreq_b++;
                if (rsp_b[pad]) cnt = lat_b;
            end
            if (b_upd) begin
                nupd_b++; upd_cyc_b = cyc;
                ub[0] = b_b0; ub[1] = b_b1; ub[2] = b_p0; ub[3] = b_p1; ub_to = b_to;
            end
            if (!b_upd && (b_p0 | b_p1) != 8'h00) bad_pr++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_b(input int win, output int got);
        int n0;
        n0 = nreq_b;
        vb_b = 1'b1; step(3); vb_b = 1'b0;
        step(win);
        got = nreq_b - n0;
    endtask

    typedef struct {
        logic [7:0] v0, v1;
        bit         r0, r1;
        logic [7:0] e_b0, e_b1, e_p0, e_p1;
        logic [1:0] e_to;
        int         e_d1;   // req1 - req0
        int         e_du;   // update - req0
    } poll_vec_t;

    typedef struct {
        bit en;
        int e_req;
    } edge_vec_t;

    poll_vec_t tv[5];
    edge_vec_t ev[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, t0, n0, nu, k;

        // SEL_SETTLE=4, latency 200: req1-req0 = 200+5; update-req0 = 205+200+1; timeout 4096 adds T+1 instead
        tv[0] = '{8'h09, 8'h40, 1, 1, 8'h09, 8'h40, 8'h09, 8'h40, 2'b00, 205, 406};
        tv[1] = '{8'h0B, 8'h00, 1, 1, 8'h0B, 8'h00, 8'h02, 8'h00, 2'b00, 205, 406};
        tv[2] = '{8'h0F, 8'h55, 1, 0, 8'h0F, 8'h00, 8'h04, 8'h00, 2'b10, 205, 4302};
        tv[3] = '{8'h0F, 8'h81, 1, 1, 8'h0F, 8'h81, 8'h00, 8'h81, 2'b00, 205, 406};
        tv[4] = '{8'hAA, 8'h03, 0, 1, 8'h0F, 8'h03, 8'h00, 8'h02, 2'b01, 4101, 4302};

        // FRAME_DIV=3 from divider 0: polls on edges 3 and 6; disabled edges do not count
        ev[0] = '{1, 0}; ev[1] = '{1, 0}; ev[2] = '{1, 2}; ev[3] = '{1, 0};
        ev[4] = '{1, 0}; ev[5] = '{1, 2}; ev[6] = '{1, 0}; ev[7] = '{0, 0};
        ev[8] = '{0, 0}; ev[9] = '{1, 0}; ev[10] = '{1, 2};

        rst_n = 1'b0; en = 1'b1; vb_a = 1'b1; vb_b = 1'b1;
        val_a[0] = 8'h00; val_a[1] = 8'h00; rsp_a[0] = 1; rsp_a[1] = 1; lat_a = 200;
        val_b[0] = 8'h05; val_b[1] = 8'h06; rsp_b[0] = 1; rsp_b[1] = 1; lat_b = 10;

        // reset state, vblank held high through release
        step(3);
        chk("reset_outputs_a", int'({a_req, a_sel, a_b0, a_b1, a_p0, a_p1, a_upd, a_to, a_busy}), 0);
        chk("reset_outputs_b", int'({b_req, b_sel, b_b0, b_b1, b_p0, b_p1, b_upd, b_to, b_busy}), 0);
        rst_n = 1'b1;
        step(10);
        chk("no_req_vblank_high_a", nreq_a, 0);
        chk("no_req_vblank_high_b", nreq_b, 0);
        vb_a = 1'b0; vb_b = 1'b0;
        step(2);

        // nominal, press-edge and timeout polls on dut_a
        for (int i = 0; i < 5; i++) begin
            val_a[0] = tv[i].v0; val_a[1] = tv[i].v1;
            rsp_a[0] = tv[i].r0; rsp_a[1] = tv[i].r1;
            n0 = nreq_a; nu = nupd_a;
            t0 = cyc;
            vb_a = 1'b1; step(3); vb_a = 1'b0;
            k = 0;
            while (nupd_a == nu && k < 6000) begin step(1); k++; end
            step(2);
            chk($sformatf("v%0d_update_seen", i), nupd_a - nu, 1);
            chk($sformatf("v%0d_req0_at_E+1", i), req_cyc_a[0] - t0, 1);
            chk($sformatf("v%0d_req_count", i), nreq_a - n0, 2);
            chk($sformatf("v%0d_req1_delay", i), req_cyc_a[1] - req_cyc_a[0], tv[i].e_d1);
            chk($sformatf("v%0d_update_delay", i), upd_cyc_a - req_cyc_a[0], tv[i].e_du);
            chk($sformatf("v%0d_p0_buttons", i), ua[0], tv[i].e_b0);
            chk($sformatf("v%0d_p1_buttons", i), ua[1], tv[i].e_b1);
            chk($sformatf("v%0d_p0_pressed", i), ua[2], tv[i].e_p0);
            chk($sformatf("v%0d_p1_pressed", i), ua[3], tv[i].e_p1);
            chk($sformatf("v%0d_timeout", i), ua_to, tv[i].e_to);
            chk($sformatf("v%0d_sel_at_update", i), ua_sel, 1);
            chk($sformatf("v%0d_busy_sel_after", i), int'({pa_busy, pa_sel}), 0);
        end

        // divider and enable on dut_b
        for (int i = 0; i < 11; i++) begin
            en = ev[i].en;
            pulse_b(60, got);
            chk($sformatf("div_edge%0d_reqs", i + 1), got, ev[i].e_req);
        end
        en = 1'b1;
        chk("div_poll_p0", ub[0], 8'h05);
        chk("div_poll_p1", ub[1], 8'h06);

        // vblank edge while WAIT0 is pending must not restart or advance anything
        val_b[0] = 8'h11; val_b[1] = 8'h22; lat_b = 30;
        pulse_b(60, got); chk("ovl_edge1_reqs", got, 0);
        pulse_b(60, got); chk("ovl_edge2_reqs", got, 0);
        n0 = nreq_b; nu = nupd_b;
        vb_b = 1'b1; step(3); vb_b = 1'b0; step(7);
        vb_b = 1'b1; step(3); vb_b = 1'b0; step(100);
        chk("ovl_req_count", nreq_b - n0, 2);
        chk("ovl_update_count", nupd_b - nu, 1);
        chk("ovl_p0_buttons", ub[0], 8'h11);
        chk("ovl_p1_buttons", ub[1], 8'h22);

        // stray strobe in IDLE, then a poll where pad 1 never answers
        stray_at_b = cyc + 2;
        step(5);
        chk("stray_no_req", nreq_b - n0, 2);
        val_b[0] = 8'h13; rsp_b[1] = 0; lat_b = 10;
        pulse_b(60, got); chk("tmo_edge1_reqs", got, 0);
        pulse_b(60, got); chk("tmo_edge2_reqs", got, 0);
        pulse_b(120, got); chk("tmo_edge3_reqs", got, 2);
        chk("tmo_wait1_exit", upd_cyc_b - req_cyc_b[1], 65);
        chk("tmo_p0_buttons", ub[0], 8'h13);
        chk("tmo_p1_buttons_kept", ub[1], 8'h22);
        chk("tmo_p0_pressed", ub[2], 8'h02);
        chk("tmo_p1_pressed", ub[3], 8'h00);
        chk("tmo_status", ub_to, 2'b10);

        // next good poll clears the pad 1 timeout bit
        rsp_b[1] = 1; val_b[1] = 8'h23;
        pulse_b(60, got);
        pulse_b(60, got);
        pulse_b(60, got); chk("recover_reqs", got, 2);
        chk("recover_p1_buttons", ub[1], 8'h23);
        chk("recover_p1_pressed", ub[3], 8'h01);
        chk("recover_p0_pressed", ub[2], 8'h00);
        chk("recover_status", ub_to, 2'b00);

        // reset while in SETTLE
        pulse_b(60, got);
        pulse_b(60, got);
        n0 = nreq_b;
        vb_b = 1'b1;
        k = 0;
        while (nreq_b == n0 && k < 20) begin step(1); k++; end
        chk("rst_seq_started", nreq_b - n0, 1);
        step(12);
        chk("rst_in_settle", int'({b_sel, b_busy}), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs_b", int'({b_req, b_sel, b_b0, b_b1, b_p0, b_p1, b_upd, b_to, b_busy}), 0);
        step(2);
        rst_n = 1'b1;
        n0 = nreq_b;
        step(20);
        chk("rst_no_req_vblank_high", nreq_b - n0, 0);
        vb_b = 1'b0;
        step(2);
        pulse_b(60, got); chk("rst_edge1_reqs", got, 0);
        pulse_b(60, got); chk("rst_edge2_reqs", got, 0);
        pulse_b(60, got); chk("rst_edge3_reqs", got, 2);

        chk("pressed_outside_update", bad_pr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
